// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and control bundles for the pipeline stall sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctl_t;

    // Bit order: pc, if_id, id_ex, ex_mem, mem_wb write enables, then if_id, id_ex, ex_mem flushes.
    localparam pipe_ctl_t CTL_FREEZE   = 8'b00000_000;
    localparam pipe_ctl_t CTL_RUN      = 8'b11111_000;
    localparam pipe_ctl_t CTL_BRANCH   = 8'b11111_111;
    localparam pipe_ctl_t CTL_LOAD_USE = 8'b00111_010;
    localparam pipe_ctl_t CTL_DRAIN    = 8'b01111_100;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard inputs and register enable/flush outputs of the stall sequencer
interface pipe_stall_ctrl_if;
    logic load_use_stop;
    logic branch_taken;
    logic dmem_busy;
    logic halt_req;
    logic resume;
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic halted;
    logic timeout_err;

    modport master (
        input  load_use_stop, branch_taken, dmem_busy, halt_req, resume,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_flush, id_ex_flush, ex_mem_flush, halted, timeout_err
    );

    modport slave (
        output load_use_stop, branch_taken, dmem_busy, halt_req, resume,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_flush, id_ex_flush, ex_mem_flush, halted, timeout_err
    );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// rtl/pipe_stall_ctrl_sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush/halt sequencer driving the five pipeline register controls
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.master bus,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic [DW-1:0]   drain_cnt, drain_nxt;
    logic            timeout_q;
    logic            stall_inc, flush_inc;
    pipe_ctl_t       ctl, ctl_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            if (wait_nxt == WW'(TIMEOUT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ctl       = CTL_FREEZE;
        wait_nxt  = wait_cnt;
        drain_nxt = drain_cnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (bus.dmem_busy) begin
                    stall_inc = 1'b1;
                    state_nxt = MEM_WAIT;
                    if (state == RUN) begin
                        wait_nxt = WW'(1);
                    end else if (wait_cnt != WW'(TIMEOUT)) begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    wait_nxt  = '0;
                    state_nxt = RUN;
                    if (bus.branch_taken) begin
                        ctl       = CTL_BRANCH;
                        flush_inc = 1'b1;
                    end else if (bus.load_use_stop) begin
                        ctl       = CTL_LOAD_USE;
                        stall_inc = 1'b1;
                    end else begin
                        ctl = CTL_RUN;
                        if (bus.halt_req) begin
                            state_nxt = DRAIN;
                            drain_nxt = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                wait_nxt = '0;
                if (bus.dmem_busy) begin
                    stall_inc = 1'b1;
                end else if (bus.branch_taken) begin
                    // PC still loads so the branch target is where execution resumes.
                    ctl       = CTL_BRANCH;
                    flush_inc = 1'b1;
                    drain_nxt = drain_cnt + 1'b1;
                end else if (bus.load_use_stop) begin
                    ctl       = CTL_LOAD_USE;
                    stall_inc = 1'b1;
                end else begin
                    ctl       = CTL_DRAIN;
                    drain_nxt = drain_cnt + 1'b1;
                end
                if (drain_nxt == DW'(DRAIN_CYCLES)) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (bus.resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Reset returns state to RUN asynchronously; gate so nothing is written while rst is held.
    assign ctl_out = rst ? CTL_FREEZE : ctl;

    assign bus.pc_we        = ctl_out.pc_we;
    assign bus.if_id_we     = ctl_out.if_id_we;
    assign bus.id_ex_we     = ctl_out.id_ex_we;
    assign bus.ex_mem_we    = ctl_out.ex_mem_we;
    assign bus.mem_wb_we    = ctl_out.mem_wb_we;
    assign bus.if_id_flush  = ctl_out.if_id_flush;
    assign bus.id_ex_flush  = ctl_out.id_ex_flush;
    assign bus.ex_mem_flush = ctl_out.ex_mem_flush;
    assign bus.halted       = (state == HALTED);
    assign bus.timeout_err  = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    pipe_stall_ctrl_if bif();

    pipe_stall_ctrl #(.DRAIN_CYCLES(4), .TIMEOUT(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc, if_id, id_ex, ex_mem, mem_wb we} then {if_id, id_ex, ex_mem flush}
    localparam logic [7:0] C_RUN = 8'b11111_000;
    localparam logic [7:0] C_FRZ = 8'b00000_000;
    localparam logic [7:0] C_BR  = 8'b11111_111;
    localparam logic [7:0] C_LU  = 8'b00111_010;
    localparam logic [7:0] C_DRN = 8'b01111_100;

    typedef struct {
        logic [7:0] ctl;
        logic       halted;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [7:0] obs_ctl();
        return {bif.pc_we, bif.if_id_we, bif.id_ex_we, bif.ex_mem_we, bif.mem_wb_we,
                bif.if_id_flush, bif.id_ex_flush, bif.ex_mem_flush};
    endfunction

    task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic br, input logic bz, input logic hr, input logic rs);
        bif.load_use_stop = lu;
        bif.branch_taken  = br;
        bif.dmem_busy     = bz;
        bif.halt_req      = hr;
        bif.resume        = rs;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cyc(input logic lu, input logic br, input logic bz, input logic hr, input logic rs,
                       input logic [7:0] ectl, input logic eh, input string tag);
        exp_t e;
        drive(lu, br, bz, hr, rs);
        sb.push_back('{ectl, eh, tag});
        #3;
        e = sb.pop_front();
        chk(obs_ctl(), e.ctl, {e.tag, "_ctl"});
        chk({7'b0, bif.halted}, {7'b0, e.halted}, {e.tag, "_halted"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        #2;
        chk(obs_ctl(), C_FRZ, "rst_ctl");
        chk({7'b0, bif.halted}, 8'd0, "rst_halted");
        chk({7'b0, bif.timeout_err}, 8'd0, "rst_timeout");
        chk({4'b0, stall_cnt}, 8'd0, "rst_stall");
        chk({4'b0, flush_cnt}, 8'd0, "rst_flush");
        @(posedge clk);
        #1;
        chk(obs_ctl(), C_FRZ, "rst_held_ctl");
        rst = 1'b0;

        cyc(0, 0, 0, 0, 0, C_RUN, 0, "idle");

        // load-use bubble
        cyc(1, 0, 0, 0, 0, C_LU, 0, "lu");
        chk({4'b0, stall_cnt}, 8'd1, "lu_stall");
        cyc(0, 0, 0, 0, 0, C_RUN, 0, "lu_after");

        // branch overrides load-use
        cyc(1, 1, 0, 0, 0, C_BR, 0, "br_lu");
        chk({4'b0, flush_cnt}, 8'd1, "br_lu_flush");
        chk({4'b0, stall_cnt}, 8'd1, "br_lu_stall");

        // memory wait with timeout
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0, 1, 0, 0, C_FRZ, 0, $sformatf("busy%0d", i));
            if (i == 3) chk({7'b0, bif.timeout_err}, 8'd0, "timeout_before");
            if (i == 4) chk({7'b0, bif.timeout_err}, 8'd1, "timeout_at");
        end
        chk({4'b0, stall_cnt}, 8'd7, "busy_stall");
        cyc(0, 0, 0, 0, 0, C_RUN, 0, "busy_exit");
        chk({7'b0, bif.timeout_err}, 8'd1, "timeout_sticky");

        // halt, drain, resume
        cyc(0, 0, 0, 1, 0, C_RUN, 0, "halt_req");
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, 0, C_DRN, 0, $sformatf("drain%0d", i));
        cyc(0, 0, 0, 0, 0, C_FRZ, 1, "halted");
        cyc(1, 1, 1, 0, 0, C_FRZ, 1, "halted_ignore");
        chk({4'b0, stall_cnt}, 8'd7, "halted_stall");
        chk({4'b0, flush_cnt}, 8'd1, "halted_flush");
        cyc(0, 0, 0, 0, 1, C_FRZ, 1, "resume");
        cyc(0, 0, 0, 0, 0, C_RUN, 0, "resumed");
        cyc(0, 0, 0, 0, 1, C_RUN, 0, "resume_in_run");
        cyc(0, 0, 0, 0, 0, C_RUN, 0, "resume_in_run_after");

        // branch and busy during drain
        cyc(0, 0, 0, 1, 0, C_RUN, 0, "halt2_req");
        cyc(0, 0, 0, 0, 0, C_DRN, 0, "d2_1");
        cyc(0, 1, 0, 0, 0, C_BR, 0, "d2_2_branch");
        chk({4'b0, flush_cnt}, 8'd2, "d2_flush");
        cyc(0, 0, 0, 0, 0, C_DRN, 0, "d2_3");
        cyc(0, 0, 1, 0, 0, C_FRZ, 0, "d2_busy_hold");
        cyc(0, 0, 0, 0, 0, C_DRN, 0, "d2_4");
        cyc(0, 0, 0, 0, 0, C_FRZ, 1, "d2_halted");
        chk({4'b0, stall_cnt}, 8'd8, "d2_stall");
        cyc(0, 0, 0, 0, 1, C_FRZ, 1, "d2_resume");
        cyc(0, 0, 0, 0, 0, C_RUN, 0, "d2_resumed");

        // asynchronous reset in the middle of a drain
        cyc(0, 0, 0, 1, 0, C_RUN, 0, "halt3_req");
        cyc(0, 0, 0, 0, 0, C_DRN, 0, "d3_1");
        drive(0, 0, 0, 0, 0);
        #1;
        chk(obs_ctl(), C_DRN, "d3_2_pre_rst");
        #1;
        rst = 1'b1;
        #1;
        chk(obs_ctl(), C_FRZ, "arst_ctl");
        chk({7'b0, bif.halted}, 8'd0, "arst_halted");
        chk({7'b0, bif.timeout_err}, 8'd0, "arst_timeout");
        chk({4'b0, stall_cnt}, 8'd0, "arst_stall");
        chk({4'b0, flush_cnt}, 8'd0, "arst_flush");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, C_RUN, 0, "arst_run1");
        cyc(0, 0, 0, 0, 0, C_RUN, 0, "arst_run2");

        // saturation
        for (int i = 1; i <= 20; i++) cyc(1, 0, 0, 0, 0, C_LU, 0, $sformatf("sat%0d", i));
        chk({4'b0, stall_cnt}, 8'd15, "sat_stall");
        chk({4'b0, flush_cnt}, 8'd0, "sat_flush");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Combines the load-use stop from the hazard detector, branch-taken from MEM and data-memory busy into per-register write enables and flushes.
- Implements a debug halt (drain to empty, then freeze) with resume, a memory-wait timeout flag and saturating event counters.
- Sits beside the pipeline registers in the top level. Drives `pc`, `if_id`, `id_ex`, `ex_mem` and `mem_wb` control.

Parameters:
- DRAIN_CYCLES, 4, number of bubble-insertion cycles before HALTED (must be ≥1).
- TIMEOUT, 64, MEM_WAIT cycles after which timeout_err sets (≥2).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- load_use_stop  in  1  load-use hazard from the hazard detector (ID vs EX).
- branch_taken  in  1  branch resolved taken in MEM this cycle.
- dmem_busy  in  1  data memory cannot complete this cycle.
- halt_req  in  1  debug halt request, level.
- resume  in  1  one-cycle pulse, leaves HALTED.
- pc_we  out  1  PC write enable.
- if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  pipeline register write enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all-zero control) on the next edge; only meaningful with the matching _we=1.
- halted  out  1  pipeline frozen in HALTED.
- timeout_err  out  1  sticky; memory wait reached TIMEOUT.
- stall_cnt  out  CNT_W  cycles frozen by load-use or dmem_busy, saturating.
- flush_cnt  out  CNT_W  branch flush events, saturating.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Enables and flushes are combinational from the state and the current inputs, so a stall acts in the same cycle it is detected.
- State, wait counter, drain counter, flags and statistics counters are registered.
- Reset (async):
  - State RUN; all counters 0; timeout_err=0; halted=0.
  - While rst=1, all _we=0 and all flushes=0.
- RUN/MEM_WAIT evaluation uses this priority each cycle:
  1. dmem_busy=1: all _we=0, flushes=0, stall_cnt+1. Next state MEM_WAIT. The wait counter increments; it is loaded with 1 on entry from RUN.
  2. branch_taken=1: all _we=1; if_id_flush, id_ex_flush and ex_mem_flush=1; flush_cnt+1. If a load-use condition is present in the same cycle, branch_taken overrides it.
  3. load_use_stop=1: pc_we=0, if_id_we=0, id_ex_we=1 with id_ex_flush=1, ex_mem_we=1, mem_wb_we=1; stall_cnt+1.
  4. halt_req=1 (RUN/MEM_WAIT only): this cycle behaves as normal flow. Next state DRAIN; drain counter cleared.
  5. Otherwise all _we=1, flushes=0.
- MEM_WAIT exit: when dmem_busy=0, the cycle is evaluated as in RUN (items 2–5), the wait counter clears and the next state is RUN (or DRAIN via item 4).
- Timeout: when the wait counter reaches TIMEOUT, timeout_err sets and stays set until rst. The pipeline keeps waiting; there is no abort.
- DRAIN:
  - Default: pc_we=0, if_id_we=1 with if_id_flush=1, other _we=1. The drain counter increments.
  - dmem_busy: freeze as in item 1; the drain counter holds.
  - branch_taken: as in item 2, but pc_we=1 so the target is captured for resume. The counter advances.
  - load_use_stop: as in item 3; the counter holds.
  - When the counter has reached DRAIN_CYCLES after the increment, the next state is HALTED.
  - Deasserting halt_req during DRAIN does not cancel the drain.
- HALTED:
  - All _we=0, flushes=0, halted=1.
  - resume=1 → RUN next cycle; halted deasserts in that cycle.
  - Other inputs are ignored; branch, load-use and busy cannot occur while empty.
  - resume outside HALTED is ignored.
- Counters: stall_cnt and flush_cnt stick at all-ones (2^CNT_W−1) and do not wrap.
- Reset mid-drain or mid-wait: returns to RUN with counters zeroed.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, DRAIN, HALTED);
  - the localparam bundle for the five enable/flush vectors, used so the top level can pack them as one struct.
- One natural sub-module: sat_counter (parameterised width, inc, async rst). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Load-use: load_use_stop=1 for 1 cycle in RUN → that cycle pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; stall_cnt 0→1; next cycle all _we=1.
- Branch vs load-use: branch_taken=1 and load_use_stop=1 together → pc_we=1; the three flushes=1; flush_cnt=1, stall_cnt=0.
- Memory wait with timeout: TIMEOUT=4, dmem_busy high 6 cycles → all _we=0 for 6 cycles; stall_cnt=6; timeout_err rises after the 4th cycle and stays high after dmem_busy drops.
- Halt/drain/resume: DRAIN_CYCLES=4, halt_req pulse → 4 cycles of pc_we=0 with if_id_flush=1; then halted=1 with all _we=0. A resume pulse → halted=0 and pc_we=1 the next cycle.
- Branch during drain: branch_taken in the 2nd drain cycle → pc_we=1 and flushes=1 that cycle; HALTED still entered after 4 counted cycles.
- Async reset: rst asserted mid-DRAIN between edges → outputs go to reset values immediately; stall_cnt/flush_cnt=0; RUN after release.
- Saturation: CNT_W=4, 20 load-use cycles → stall_cnt=15, no wrap.
